// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port data memory between the CPU memory
// stage and a DMA/debug master. The CPU has priority. A starvation counter
// forces a waiting DMA beat through, and a burst limit bounds how long the
// DMA can hold the memory.
module dmem_arbiter #(
    parameter int unsigned AW           = 32,
    parameter int unsigned DW           = 32,
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned MAX_BURST    = 4
) (
    input  logic          clk,
    input  logic          rst,
    // CPU memory-stage port
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_stall,
    // DMA / debug port
    input  logic          dma_valid,
    input  logic          dma_we,
    input  logic          dma_last,
    input  logic [AW-1:0] dma_addr,
    input  logic [DW-1:0] dma_wdata,
    output logic          dma_ready,
    output logic          dma_rvalid,
    output logic [DW-1:0] dma_rdata,
    // Data memory port
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam int BW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
    localparam logic [BW-1:0] BEAT_LAST  = BW'(MAX_BURST - 1);

    typedef enum logic {
        S_CPU = 1'b0,
        S_DMA = 1'b1
    } state_t;

    state_t        state, state_next;
    logic [SW-1:0] starve_cnt;
    logic [BW-1:0] beat_cnt, beat_next;
    logic          cpu_gnt;

    // Grant decision: CPU first unless the DMA is starved or owns a burst.
    always_comb begin
        // NOTE: every output of a combinational block gets a default up front,
        // so no path leaves a signal unassigned and no latch is inferred.
        dma_ready = 1'b0;
        cpu_gnt   = 1'b0;
        if (!rst) begin
            if (state == S_CPU) begin
                dma_ready = dma_valid && (!cpu_req || starve_cnt == STARVE_MAX);
                cpu_gnt   = cpu_req && !dma_ready;
            end else begin
                dma_ready = dma_valid;
                cpu_gnt   = cpu_req && !dma_valid;
            end
        end
        cpu_stall = !rst && cpu_req && !cpu_gnt;
        cpu_rdata = mem_rdata;
    end

    // Memory port mux: the granted master drives the memory; idle defaults to CPU.
    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = cpu_addr;
        mem_wdata = cpu_wdata;
        if (dma_ready) begin
            mem_we    = dma_we;
            mem_addr  = dma_addr;
            mem_wdata = dma_wdata;
        end else if (cpu_gnt) begin
            mem_we    = cpu_we;
        end
    end

    // Next-state logic: enter a burst on a non-final beat, leave on the
    // final beat, on the burst limit, or when the DMA pauses and the CPU waits.
    always_comb begin
        state_next = state;
        beat_next  = beat_cnt;
        if (state == S_CPU) begin
            if (dma_ready && !dma_last && MAX_BURST > 1) begin
                state_next = S_DMA;
                beat_next  = BW'(1);
            end
        end else begin
            if (dma_ready) begin
                if (dma_last || beat_cnt == BEAT_LAST) begin
                    state_next = S_CPU;
                    beat_next  = '0;
                end else begin
                    beat_next  = beat_cnt + BW'(1);
                end
            end else if (cpu_req) begin
                state_next = S_CPU;
                beat_next  = '0;
            end
        end
    end

    // State, burst and starvation registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (rst) begin
            state      <= S_CPU;
            beat_cnt   <= '0;
            starve_cnt <= '0;
        end else begin
            state    <= state_next;
            beat_cnt <= beat_next;
            if (dma_ready)
                starve_cnt <= '0;
            else if (dma_valid && starve_cnt != STARVE_MAX)
                starve_cnt <= starve_cnt + SW'(1);
        end
    end

    // DMA read return: capture memory data one cycle after an accepted read.
    always_ff @(posedge clk) begin
        // NOTE: the read-data register is reset too, so the DMA side never
        // observes X after reset even though dma_rvalid already qualifies it.
        if (rst) begin
            dma_rvalid <= 1'b0;
            dma_rdata  <= '0;
        end else begin
            dma_rvalid <= dma_ready && !dma_we;
            if (dma_ready && !dma_we)
                dma_rdata <= mem_rdata;
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed testbench for dmem_arbiter with a behavioural single-port memory.
module tb_dmem_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          cpu_req, cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata, cpu_rdata;
    logic          cpu_stall;
    logic          dma_valid, dma_we, dma_last;
    logic [AW-1:0] dma_addr;
    logic [DW-1:0] dma_wdata;
    logic          dma_ready, dma_rvalid;
    logic [DW-1:0] dma_rdata;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;

    logic          mem_init;
    logic [DW-1:0] mem [0:255];

    int checks = 0;
    int errors = 0;

    dmem_arbiter #(.AW(AW), .DW(DW), .STARVE_LIMIT(4), .MAX_BURST(4)) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .dma_valid(dma_valid), .dma_we(dma_we), .dma_last(dma_last),
        .dma_addr(dma_addr), .dma_wdata(dma_wdata), .dma_ready(dma_ready),
        .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Word-addressed memory: combinational read, synchronous write.
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 256; i++) mem[i] <= 32'hA000_0000 + i;
        end else if (mem_we) begin
            mem[mem_addr[9:2]] <= mem_wdata;
        end
    end
    assign mem_rdata = mem[mem_addr[9:2]];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic idle();
        cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
        dma_valid = 0; dma_we = 0; dma_last = 0; dma_addr = '0; dma_wdata = '0;
    endtask

    task automatic cpu_drive(input logic we, input logic [31:0] addr, input logic [31:0] data);
        cpu_req = 1; cpu_we = we; cpu_addr = addr; cpu_wdata = data;
    endtask

    task automatic dma_drive(input logic we, input logic last, input logic [31:0] addr,
                             input logic [31:0] data);
        dma_valid = 1; dma_we = we; dma_last = last; dma_addr = addr; dma_wdata = data;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic        prev_beat;
        logic        beat_now;
        int          idx;

        // ---------------- reset: no grants while rst is high -------------
        idle();
        rst = 1; mem_init = 1;
        cpu_drive(1, 32'h10, 32'h1234);
        dma_drive(1, 0, 32'h20, 32'h5678);
        #1;
        check("rst_dma_ready", dma_ready, 0);
        check("rst_cpu_stall", cpu_stall, 0);
        check("rst_mem_we", mem_we, 0);
        @(negedge clk); #1;
        check("rst_dma_ready2", dma_ready, 0);
        @(negedge clk);
        rst = 0; mem_init = 0; idle(); #1;
        check("post_rst_state", dut.state, 0);
        check("post_rst_starve", dut.starve_cnt, 0);
        check("post_rst_rvalid", dma_rvalid, 0);
        check("post_rst_rdata", dma_rdata, 0);

        // ---------------- CPU only: store then load ----------------------
        @(negedge clk);
        cpu_drive(1, 32'h10, 32'hDEAD_BEEF); #1;
        check("cpu_st_stall", cpu_stall, 0);
        check("cpu_st_we", mem_we, 1);
        check("cpu_st_addr", mem_addr, 32'h10);
        @(negedge clk);
        cpu_drive(0, 32'h10, 32'h0); #1;
        check("cpu_ld_stall", cpu_stall, 0);
        check("cpu_ld_data", cpu_rdata, 32'hDEAD_BEEF);
        check("cpu_ld_we", mem_we, 0);

        // ---------------- DMA only: 3-beat write burst -------------------
        for (int b = 0; b < 3; b++) begin
            @(negedge clk);
            idle();
            dma_drive(1, b == 2, 32'h20 + 4 * b, 32'h11 * (b + 1)); #1;
            check("dma_wr_ready", dma_ready, 1);
            check("dma_wr_we", mem_we, 1);
        end
        @(negedge clk);
        idle(); #1;
        check("dma_wr_state", dut.state, 0);
        check("dma_wr_rvalid", dma_rvalid, 0);
        for (int b = 0; b < 3; b++) begin
            @(negedge clk);
            cpu_drive(0, 32'h20 + 4 * b, 32'h0); #1;
            check("dma_wr_mem", cpu_rdata, 32'h11 * (b + 1));
        end

        // ---------------- starvation: forced in on cycle 4 ---------------
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            cpu_drive(0, 32'h10, 32'h0);
            dma_drive(1, 1, 32'h40, 32'h55); #1;
            check("starve_ready", dma_ready, c == 4);
            check("starve_stall", cpu_stall, c == 4);
        end
        @(negedge clk);
        idle(); cpu_drive(0, 32'h40, 32'h0); #1;
        check("starve_cnt_clr", dut.starve_cnt, 0);
        check("starve_stall_after", cpu_stall, 0);
        check("starve_mem", cpu_rdata, 32'h55);

        // ---------------- burst bound: 4 beats then CPU ------------------
        prev_beat = 0;
        idx = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            idle();
            cpu_drive(0, 32'h10, 32'h0);
            if (c < 9) dma_drive(0, 0, 32'h80 + 4 * idx, 32'h0);
            #1;
            beat_now = (c >= 4 && c < 8);
            check("burst_ready", dma_ready, beat_now);
            check("burst_stall", cpu_stall, beat_now);
            check("burst_rvalid", dma_rvalid, prev_beat);
            if (prev_beat)
                check("burst_rdata", dma_rdata, 32'hA000_0020 + idx - 1);
            if (c == 8)
                check("burst_cpu_data", cpu_rdata, 32'hDEAD_BEEF);
            if (beat_now) idx++;
            prev_beat = beat_now;
        end

        // ---------------- yield: DMA pauses mid-burst --------------------
        @(negedge clk);
        idle(); dma_drive(1, 0, 32'hC0, 32'h1111); #1;
        check("yield_beat1", dma_ready, 1);
        @(negedge clk);
        idle(); #1;
        check("idle_stays_dma", dut.state, 1);
        @(negedge clk);
        cpu_drive(0, 32'h10, 32'h0); dma_drive(1, 0, 32'hC4, 32'h2222); #1;
        check("sdma_dma_wins", dma_ready, 1);
        check("sdma_cpu_stall", cpu_stall, 1);
        @(negedge clk);
        idle(); cpu_drive(0, 32'h10, 32'h0); #1;
        check("yield_stall", cpu_stall, 0);
        check("yield_ready", dma_ready, 0);
        check("yield_data", cpu_rdata, 32'hDEAD_BEEF);
        @(negedge clk);
        cpu_drive(0, 32'h10, 32'h0); dma_drive(1, 0, 32'hC8, 32'h3333); #1;
        check("yield_state", dut.state, 0);
        check("yield_beat_cnt", dut.beat_cnt, 0);
        check("yield_cpu_prio", dma_ready, 0);

        // ---------------- reset mid-burst --------------------------------
        for (int b = 0; b < 2; b++) begin
            @(negedge clk);
            idle(); dma_drive(0, 0, 32'hD0 + 4 * b, 32'h0); #1;
            check("rstb_ready", dma_ready, 1);
        end
        @(negedge clk);
        rst = 1;
        cpu_drive(1, 32'h10, 32'h9999);
        dma_drive(1, 0, 32'hD8, 32'h7777); #1;
        check("rstb_dma_ready", dma_ready, 0);
        check("rstb_mem_we", mem_we, 0);
        check("rstb_stall", cpu_stall, 0);
        @(negedge clk);
        rst = 0; idle(); #1;
        check("rstb_state", dut.state, 0);
        check("rstb_beat_cnt", dut.beat_cnt, 0);
        check("rstb_rvalid", dma_rvalid, 0);
        check("rstb_rdata", dma_rdata, 0);
        @(negedge clk);
        cpu_drive(0, 32'h10, 32'h0); #1;
        check("rstb_mem_kept", cpu_rdata, 32'hDEAD_BEEF);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
